// File: rtl/gate_truth_checker.sv
// Exhaustive stimulus driver and response checker for small combinational gate cells.
// Each input vector is held for SETTLE cycles, then the output is compared against TRUTH in one SAMPLE cycle.
module gate_truth_checker #(
    parameter int unsigned               N_IN   = 2,
    parameter int unsigned               SETTLE = 2,
    parameter logic [(1 << N_IN) - 1:0]  TRUTH  = 4'b1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dut_out,
    output logic [N_IN-1:0] dut_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            mismatch,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [N_IN-1:0] dut_in_n;
    logic            busy_n, done_n, mismatch_n;
    logic [N_IN:0]   err_count_n;
    logic [N_IN-1:0] first_fail_vec_n;
    logic            first_fail_valid_n;
    logic            vec_fail;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            dut_in           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            mismatch         <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            dut_in           <= dut_in_n;
            busy             <= busy_n;
            done             <= done_n;
            mismatch         <= mismatch_n;
            err_count        <= err_count_n;
            first_fail_vec   <= first_fail_vec_n;
            first_fail_valid <= first_fail_valid_n;
        end
    end

    // Identity compare: an X or Z on a floating/contended net never matches.
    assign vec_fail = (dut_out !== TRUTH[dut_in]);

    always_comb begin
        state_n            = state;
        cnt_n              = cnt;
        dut_in_n           = dut_in;
        busy_n             = busy;
        done_n             = done;
        mismatch_n         = 1'b0;
        err_count_n        = err_count;
        first_fail_vec_n   = first_fail_vec;
        first_fail_valid_n = first_fail_valid;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n            = ST_SETTLE;
                    cnt_n              = CW'(SETTLE - 1);
                    dut_in_n           = '0;
                    busy_n             = 1'b1;
                    done_n             = 1'b0;
                    err_count_n        = '0;
                    first_fail_vec_n   = '0;
                    first_fail_valid_n = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    state_n = ST_SAMPLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (vec_fail) begin
                    err_count_n = err_count + 1'b1;
                    mismatch_n  = 1'b1;
                    if (!first_fail_valid) begin
                        first_fail_vec_n   = dut_in;
                        first_fail_valid_n = 1'b1;
                    end
                end
                if (dut_in == '1) begin
                    state_n = ST_DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    state_n  = ST_SETTLE;
                    dut_in_n = dut_in + 1'b1;
                    cnt_n    = CW'(SETTLE - 1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two checkers (AND and NAND truth tables) observe a shared behavioural gate model.
// Per-vector expected failures are queued when each vector appears and retired when mismatch/err_count update.
module tb_gate_truth_checker;

    localparam int unsigned NI = 2;
    localparam int unsigned ST = 2;
    localparam int unsigned NV = 1 << NI;
    localparam int unsigned SWEEP_LAST = 1 + NV * (ST + 1);

    localparam int M_AND   = 0;
    localparam int M_STUCK = 1;
    localparam int M_FLOAT = 2;
    localparam int M_NAND  = 3;

    logic clk = 1'b0;
    logic rst;
    logic start;
    int   mode;

    logic [NI-1:0] in_a, in_b, ffv_a, ffv_b;
    logic          y_a, y_b;
    logic          busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic          mm_a, mm_b, ffok_a, ffok_b;
    logic [NI:0]   err_a, err_b;

    logic [NV-1:0] truth_a = 4'b1000;
    logic [NV-1:0] truth_b = 4'b0111;

    typedef struct packed {
        logic fa;
        logic fb;
    } sb_t;
    sb_t sbq[$];

    int n_pass  = 0;
    int n_total = 0;

    int unsigned   fin_ea, fin_eb;
    logic [NI-1:0] fin_fva, fin_fvb;
    logic          fin_oka, fin_okb;

    always #5 clk = ~clk;

    gate_truth_checker #(.N_IN(NI), .SETTLE(ST), .TRUTH(4'b1000)) u_and (
        .clk(clk), .rst(rst), .start(start), .dut_out(y_a), .dut_in(in_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .mismatch(mm_a),
        .err_count(err_a), .first_fail_vec(ffv_a), .first_fail_valid(ffok_a)
    );

    gate_truth_checker #(.N_IN(NI), .SETTLE(ST), .TRUTH(4'b0111)) u_nand (
        .clk(clk), .rst(rst), .start(start), .dut_out(y_b), .dut_in(in_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .mismatch(mm_b),
        .err_count(err_b), .first_fail_vec(ffv_b), .first_fail_valid(ffok_b)
    );

    // Cell under test; a missing pull-up leaves the output unknown for the low vectors.
    function automatic logic gate_fn(input int m, input logic [NI-1:0] v);
        case (m)
            M_AND:   return &v;
            M_STUCK: return 1'b0;
            M_FLOAT: return (v == 2'd3) ? 1'b1 : 1'bx;
            M_NAND:  return ~&v;
            default: return 1'bx;
        endcase
    endfunction

    always_comb begin
        y_a = gate_fn(mode, in_a);
        y_b = gate_fn(mode, in_b);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_a"}, 32'({in_a, busy_a, done_a, pass_a, mm_a, err_a, ffv_a, ffok_a}), 32'd0);
        check({tag, "_b"}, 32'({in_b, busy_b, done_b, pass_b, mm_b, err_b, ffv_b, ffok_b}), 32'd0);
    endtask

    // Pulses start at cycle 0 and walks cycle by cycle to done; optional start re-pulse
    // during cycle restart_at and reset during cycle abort_at (0 disables either).
    task automatic run_sweep(input int m, input int restart_at, input int abort_at);
        int unsigned   ea, eb;
        logic [NI-1:0] fva, fvb;
        logic          oka, okb;
        int            phase, k;
        sb_t           e;
        ea = 0; eb = 0; fva = '0; fvb = '0; oka = 1'b0; okb = 1'b0;
        mode  = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= int'(SWEEP_LAST); cyc++) begin
            if (cyc > 1) begin
                @(posedge clk); #1;
            end
            if (restart_at != 0 && cyc == restart_at + 1) start = 1'b0;
            phase = (cyc - 1) % (ST + 1);
            k     = (cyc - 1) / (ST + 1);
            if (cyc == 1) begin
                check("start_clear", 32'({done_a, pass_a, err_a, ffok_a, done_b, err_b, ffok_b}), 32'd0);
            end
            if (phase == 0 && cyc > 1) begin
                if (sbq.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    if (e.fa) begin
                        ea++;
                        if (!oka) begin fva = NI'(k - 1); oka = 1'b1; end
                    end
                    if (e.fb) begin
                        eb++;
                        if (!okb) begin fvb = NI'(k - 1); okb = 1'b1; end
                    end
                    check("mismatch_a", 32'(mm_a), 32'(e.fa));
                    check("mismatch_b", 32'(mm_b), 32'(e.fb));
                    check("err_a", 32'(err_a), ea);
                    check("err_b", 32'(err_b), eb);
                    check("first_a", 32'({ffok_a, ffv_a}), 32'({oka, fva}));
                    check("first_b", 32'({ffok_b, ffv_b}), 32'({okb, fvb}));
                end
            end else begin
                check("mismatch_quiet", 32'({mm_a, mm_b}), 32'd0);
            end
            if (k < int'(NV)) begin
                check("vec_a", 32'(in_a), 32'(k));
                check("vec_b", 32'(in_b), 32'(k));
                check("busy", 32'({busy_a, busy_b, done_a, done_b}), 32'b1100);
                if (phase == 0) begin
                    e.fa = (y_a !== truth_a[k]);
                    e.fb = (y_b !== truth_b[k]);
                    sbq.push_back(e);
                end
            end else begin
                check("done", 32'({busy_a, busy_b, done_a, done_b}), 32'b0011);
                check("pass_a", 32'(pass_a), 32'(ea == 0));
                check("pass_b", 32'(pass_b), 32'(eb == 0));
                check("last_vec", 32'({in_a, in_b}), 32'hF);
            end
            if (restart_at != 0 && cyc == restart_at) start = 1'b1;
            if (abort_at != 0 && cyc == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check_reset("abort_reset");
                rst = 1'b0;
                sbq.delete();
                return;
            end
        end
        check("sb_drained", 32'(sbq.size()), 32'd0);
        fin_ea = ea; fin_eb = eb; fin_fva = fva; fin_fvb = fvb; fin_oka = oka; fin_okb = okb;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = M_AND;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset("idle");

        // Correct AND cell; start re-pulse mid-sweep must be ignored.
        run_sweep(M_AND, 5, 0);
        check("and_pass", 32'({pass_a, err_a, ffok_a}), 32'b1_000_0);
        check("and_vs_nand_err", 32'(err_b), 32'd4);

        // Held results in DONE with no start.
        @(posedge clk); #1;
        check("done_hold", 32'({done_a, pass_a, in_a}), 32'b1_1_11);

        run_sweep(M_STUCK, 0, 0);
        check("stuck_err", 32'(err_a), 32'd1);
        check("stuck_first", 32'({ffok_a, ffv_a}), 32'b1_11);
        check("stuck_pass", 32'(pass_a), 32'd0);

        run_sweep(M_FLOAT, 0, 0);
        check("float_err", 32'(err_a), fin_ea);
        check("float_first", 32'({ffok_a, ffv_a}), 32'({fin_oka, fin_fva}));

        run_sweep(M_NAND, 0, 0);
        check("nand_pass", 32'({pass_b, err_b}), 32'b1_000);
        check("nand_vs_and_err", 32'(err_a), 32'd4);
        check("nand_vs_and_first", 32'({ffok_a, ffv_a}), 32'b1_00);

        run_sweep(M_NAND, 0, 7);
        @(posedge clk); #1;
        check_reset("post_abort_idle");

        run_sweep(M_AND, 0, 0);
        check("after_abort_pass", 32'({pass_a, err_a}), 32'b1_000);
        check("after_abort_b", 32'(err_b), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Sequential exhaustive-stimulus driver and response checker for the team's switch-level CMOS gate cells (AND, NAND, inverter and similar). It drives every input combination of the gate under test in turn and waits a programmable settle time after each one. It then samples the gate output and compares it against a parameterised truth table. The result is reported as a pass/fail summary with an error count and the first failing vector. It sits in the testbench layer as the driving and observing end of a gate cell's input/output pins, and is reused across all cell exercises.

## Interface
- `N_IN`, default 2: number of gate inputs; supported range 1..4.
- `SETTLE`, default 2: cycles each vector is held before sampling; minimum 1.
- `TRUTH`, default 4'b1000: expected output, bit k = expected `dut_out` for input vector k (default is AND); width 2^N_IN.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE.
- `dut_out`  in  1  output of the gate under test.
- `dut_in`  out  N_IN  input vector driven to the gate.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  high in DONE until restart or reset.
- `pass`  out  1  `done` AND `err_count==0`.
- `mismatch`  out  1  one-cycle strobe in a SAMPLE cycle that fails.
- `err_count`  out  N_IN+1  number of failing vectors in the current/last sweep.
- `first_fail_vec`  out  N_IN  index of the first failing vector.
- `first_fail_valid`  out  1  `first_fail_vec` holds a captured value.

## Operation
- There is one clock domain and synchronous active-high reset. Reset values: state=IDLE, `dut_in`=0, `busy`=0, `done`=0, `pass`=0, `mismatch`=0, `err_count`=0, `first_fail_vec`=0, `first_fail_valid`=0.
- States:
  - **IDLE**: waits for `start`.
  - **SETTLE**: the vector is held and the settle counter runs.
  - **SAMPLE**: one cycle in which the output is compared.
  - **DONE**: results are held.
- Transitions:
  - IDLE/DONE with `start`=1 → SETTLE. In the same edge: `dut_in`=0, settle counter=SETTLE-1, `err_count`/`first_fail_*`/`done`/`pass` cleared, `busy`=1.
  - SETTLE → SAMPLE when the counter reaches 0; otherwise the counter decrements.
  - SAMPLE with `dut_in` < 2^N_IN-1 → SETTLE. `dut_in` increments and the counter reloads to SETTLE-1.
  - SAMPLE with `dut_in` = 2^N_IN-1 → DONE. `busy`=0 and `done`=1.
- Compare rule: a vector fails unless `dut_out` is exactly equal to `TRUTH[dut_in]`, using 4-state identity. Therefore X or Z on `dut_out` is always a failure. This catches floating or contended switch-level nets.
- On a failure:
  - `err_count` increments. It cannot overflow, because its maximum is 2^N_IN.
  - `mismatch` pulses for that cycle.
  - If `first_fail_valid`=0, the block captures `first_fail_vec`=`dut_in` and sets `first_fail_valid`=1.
- `dut_in` is stable for the whole SETTLE+SAMPLE window of a vector and changes only on a SAMPLE→SETTLE edge. After a sweep it holds its last value, 2^N_IN-1, in DONE. It returns to 0 only on restart or reset.
- `start` behaviour:
  - Ignored while `busy`=1.
  - A `start` held high in DONE restarts immediately.
- Reset mid-sweep aborts the sweep. All outputs take their reset values on that edge, and no partial results are retained.

## Timing
- The start edge is cycle 0. Vector k is driven from cycle 1+k·(SETTLE+1).
- Vector k is sampled in cycle (k+1)·(SETTLE+1).
- `done` rises at cycle 1+2^N_IN·(SETTLE+1). With the defaults this is cycle 13.
- `mismatch` and `err_count` update on the edge that ends the SAMPLE cycle. They are visible in the cycle after SAMPLE, coincident with the next vector or with `done`.
- Sweep length is 2^N_IN·(SETTLE+1) cycles plus 1 start cycle.

## Test plan
- **Correct AND cell, defaults, `start` pulsed at cycle 0:**
  - `dut_in` walks 0,1,2,3, each held 3 cycles.
  - `done`=1 and `pass`=1 at cycle 13; `err_count`=0; `first_fail_valid`=0.
- **AND cell with output stuck-at-0:**
  - Exactly one mismatch pulse, following the vector-3 sample.
  - `err_count`=1, `first_fail_vec`=3, `pass`=0.
- **Pull-up network removed (output floats to Z for vectors 0–2):**
  - `err_count`=3, `first_fail_vec`=0.
  - Confirms that Z counts as a failure.
- **`TRUTH`=4'b0111 against a correct NAND cell:** `pass`=1. The same bench against the AND cell gives `err_count`=4.
- **`start` re-pulsed at cycle 5 mid-sweep:**
  - Ignored; `done` still rises at cycle 13.
  - Then `start` in DONE clears results and `done` falls the next cycle.
- **`rst` asserted at cycle 7 of a failing sweep:** all outputs are at reset values the next cycle, and a new `start` produces a full, correct sweep.
